// File: rtl/bus_slot_sequencer_pkg.sv
// Shared slot constants, bus-owner encoding and the configuration legality check
// for the PET bus slot sequencer.
package bus_slot_sequencer_pkg;

    localparam int DEF_CYCLE_CLKS  = 16;
    localparam int DEF_PI_START    = 1;
    localparam int DEF_CPU_START   = 8;
    localparam int DEF_SETUP_CLKS  = 1;
    localparam int DEF_STROBE_CLKS = 4;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_PI  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        PI_IDLE = 2'd0,
        PI_BUSY = 2'd1,
        PI_DONE = 2'd2
    } pi_state_e;

    // Both slots (setup + strobe + hold) must fit before the next slot begins.
    function automatic bit slot_cfg_legal(input int cycle_clks, input int pi_start,
                                          input int cpu_start, input int setup_clks,
                                          input int strobe_clks);
        return (pi_start >= 0) && (setup_clks >= 0) && (strobe_clks >= 1) &&
               (pi_start + setup_clks + strobe_clks + 1 <= cpu_start) &&
               (cpu_start + setup_clks + strobe_clks + 1 <= cycle_clks);
    endfunction

endpackage

// File: rtl/bus_slot_sequencer_if.sv
// Bus-side signal bundle of the slot sequencer: RPi handshake, CPU R/W and strobes.
// Build option: BUS_SLOT_CPU_STALL_EN adds the cpu_stall request line.
interface bus_slot_sequencer_if;

    logic pi_req;
    logic pi_rw_b;
    logic pi_ack;
    logic cpu_rw_b;
    logic phi2;
    logic bus_owner;
    logic cpu_read_strobe;
    logic cpu_write_strobe;
    logic pi_read_strobe;
    logic pi_write_strobe;
`ifdef BUS_SLOT_CPU_STALL_EN
    logic cpu_stall;

    modport master (
        output pi_req, pi_rw_b, cpu_rw_b, cpu_stall,
        input  pi_ack, phi2, bus_owner,
        input  cpu_read_strobe, cpu_write_strobe, pi_read_strobe, pi_write_strobe
    );

    modport slave (
        input  pi_req, pi_rw_b, cpu_rw_b, cpu_stall,
        output pi_ack, phi2, bus_owner,
        output cpu_read_strobe, cpu_write_strobe, pi_read_strobe, pi_write_strobe
    );
`else
    modport master (
        output pi_req, pi_rw_b, cpu_rw_b,
        input  pi_ack, phi2, bus_owner,
        input  cpu_read_strobe, cpu_write_strobe, pi_read_strobe, pi_write_strobe
    );

    modport slave (
        input  pi_req, pi_rw_b, cpu_rw_b,
        output pi_ack, phi2, bus_owner,
        output cpu_read_strobe, cpu_write_strobe, pi_read_strobe, pi_write_strobe
    );
`endif

endinterface

// File: rtl/bus_slot_sequencer_slot_strobe_gen.sv
// Registered read/write strobe and hold-flag generator for one access slot,
// decoded from the slot counter value that becomes current after the next edge.
module slot_strobe_gen #(
    parameter int CW    = 4,
    parameter int START = 1,
    parameter int SETUP = 1,
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] i_count_next,
    input  logic          i_rw,
    input  logic          i_enable,
    output logic          o_read_strobe,
    output logic          o_write_strobe,
    output logic          o_hold
);

    localparam int STROBE_FIRST = START + SETUP;
    localparam int STROBE_LAST  = START + SETUP + WIDTH - 1;
    localparam int HOLD_AT      = START + SETUP + WIDTH;

    logic r_rw;
    logic r_read_strobe;
    logic r_write_strobe;
    logic r_hold;
    logic w_first;
    logic w_in_strobe;
    logic w_rw;

    assign w_first     = (int'(i_count_next) == STROBE_FIRST);
    assign w_in_strobe = (int'(i_count_next) >= STROBE_FIRST) &&
                         (int'(i_count_next) <= STROBE_LAST);
    // Direction is taken on the edge that opens the strobe and frozen for its width.
    assign w_rw        = w_first ? i_rw : r_rw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rw           <= 1'b0;
            r_read_strobe  <= 1'b0;
            r_write_strobe <= 1'b0;
            r_hold         <= 1'b0;
        end else begin
            if (w_first) begin
                r_rw <= i_rw;
            end
            r_read_strobe  <= i_enable && w_in_strobe && w_rw;
            r_write_strobe <= i_enable && w_in_strobe && !w_rw;
            r_hold         <= i_enable && (int'(i_count_next) == HOLD_AT);
        end
    end

    assign o_read_strobe  = r_read_strobe;
    assign o_write_strobe = r_write_strobe;
    assign o_hold         = r_hold;

endmodule

// File: rtl/bus_slot_sequencer.sv
// Time-slot scheduler sharing the PET bus between the 6502 and the RPi bridge.
// Build option: define BUS_SLOT_CPU_STALL_EN to let cpu_stall suppress a CPU cycle.
module bus_slot_sequencer
    import bus_slot_sequencer_pkg::*;
#(
    parameter int CYCLE_CLKS  = DEF_CYCLE_CLKS,
    parameter int PI_START    = DEF_PI_START,
    parameter int CPU_START   = DEF_CPU_START,
    parameter int SETUP_CLKS  = DEF_SETUP_CLKS,
    parameter int STROBE_CLKS = DEF_STROBE_CLKS
) (
    input logic                 clk,
    input logic                 reset,
    bus_slot_sequencer_if.slave bus
);

    localparam int CW        = (CYCLE_CLKS > 1) ? $clog2(CYCLE_CLKS) : 1;
    localparam int PI_SAMPLE = (PI_START == 0) ? CYCLE_CLKS - 1 : PI_START - 1;
    localparam int PI_HOLD   = PI_START + SETUP_CLKS + STROBE_CLKS;

    if (!slot_cfg_legal(CYCLE_CLKS, PI_START, CPU_START, SETUP_CLKS, STROBE_CLKS)) begin : g_illegal_cfg
        $error("bus_slot_sequencer: slots do not fit in CYCLE_CLKS");
    end

    logic [CW-1:0] r_count;
    pi_state_e     r_state;
    logic          r_pi_rw;
    logic          r_phi2;
    owner_e        r_bus_owner;

    logic [CW-1:0] w_count_next;
    logic          w_pi_grant;
    logic          w_pi_enable;
    logic          w_pi_rw;
    logic          w_pi_in_owner;
    logic          w_cpu_enable;
    logic          w_pi_read_strobe;
    logic          w_pi_write_strobe;
    logic          w_pi_hold;
    logic          w_cpu_read_strobe;
    logic          w_cpu_write_strobe;
    logic          w_cpu_hold;

    assign w_count_next = (r_count == CW'(CYCLE_CLKS - 1)) ? '0 : r_count + 1'b1;

    // Grant is decided on the edge leaving the sample count, so the slot can
    // start one clock later with the latched direction already in place.
    assign w_pi_grant    = (int'(r_count) == PI_SAMPLE) && bus.pi_req && (r_state == PI_IDLE);
    assign w_pi_enable   = w_pi_grant || (r_state == PI_BUSY);
    assign w_pi_rw       = w_pi_grant ? bus.pi_rw_b : r_pi_rw;
    assign w_pi_in_owner = (int'(w_count_next) >= PI_START) && (int'(w_count_next) <= PI_HOLD);

`ifdef BUS_SLOT_CPU_STALL_EN
    logic r_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= 1'b0;
        end else if (int'(r_count) == CYCLE_CLKS - 1) begin
            r_stall <= bus.cpu_stall;
        end
    end

    assign w_cpu_enable = !r_stall;
`else
    assign w_cpu_enable = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_state     <= PI_IDLE;
            r_pi_rw     <= 1'b0;
            r_phi2      <= 1'b0;
            r_bus_owner <= OWNER_CPU;
        end else begin
            r_count     <= w_count_next;
            r_phi2      <= w_cpu_enable && (int'(w_count_next) >= CPU_START);
            r_bus_owner <= (w_pi_enable && w_pi_in_owner) ? OWNER_PI : OWNER_CPU;
            case (r_state)
                PI_IDLE: begin
                    if (w_pi_grant) begin
                        r_state <= PI_BUSY;
                        r_pi_rw <= bus.pi_rw_b;
                    end
                end
                PI_BUSY: begin
                    if (int'(w_count_next) == PI_HOLD) begin
                        r_state <= PI_DONE;
                    end
                end
                PI_DONE: begin
                    // Served until the requester is seen low, so a held request is not re-served.
                    if (!bus.pi_req) begin
                        r_state <= PI_IDLE;
                    end
                end
                default: r_state <= PI_IDLE;
            endcase
        end
    end

    slot_strobe_gen #(
        .CW    (CW),
        .START (PI_START),
        .SETUP (SETUP_CLKS),
        .WIDTH (STROBE_CLKS)
    ) u_pi_slot (
        .clk            (clk),
        .reset          (reset),
        .i_count_next   (w_count_next),
        .i_rw           (w_pi_rw),
        .i_enable       (w_pi_enable),
        .o_read_strobe  (w_pi_read_strobe),
        .o_write_strobe (w_pi_write_strobe),
        .o_hold         (w_pi_hold)
    );

    slot_strobe_gen #(
        .CW    (CW),
        .START (CPU_START),
        .SETUP (SETUP_CLKS),
        .WIDTH (STROBE_CLKS)
    ) u_cpu_slot (
        .clk            (clk),
        .reset          (reset),
        .i_count_next   (w_count_next),
        .i_rw           (bus.cpu_rw_b),
        .i_enable       (w_cpu_enable),
        .o_read_strobe  (w_cpu_read_strobe),
        .o_write_strobe (w_cpu_write_strobe),
        .o_hold         (w_cpu_hold)
    );

    assign bus.phi2             = r_phi2;
    assign bus.bus_owner        = r_bus_owner;
    assign bus.pi_read_strobe   = w_pi_read_strobe;
    assign bus.pi_write_strobe  = w_pi_write_strobe;
    assign bus.pi_ack           = w_pi_hold;
    assign bus.cpu_read_strobe  = w_cpu_read_strobe;
    assign bus.cpu_write_strobe = w_cpu_write_strobe;

    logic w_unused;
    assign w_unused = w_cpu_hold;

endmodule

// File: tb/tb_bus_slot_sequencer.sv
// Self-checking bench for bus_slot_sequencer: per-cycle vector table, directed
// handshake/reset/stall sequences and a randomized requester against a slot-rule model.
module tb_bus_slot_sequencer;
    import bus_slot_sequencer_pkg::*;

    localparam int CYC       = DEF_CYCLE_CLKS;
    localparam int PI_SAMPLE = (DEF_PI_START == 0) ? CYC - 1 : DEF_PI_START - 1;
    localparam int PI_S0     = DEF_PI_START + DEF_SETUP_CLKS;
    localparam int PI_S1     = PI_S0 + DEF_STROBE_CLKS - 1;
    localparam int PI_HOLD   = PI_S1 + 1;
    localparam int CPU_SAMP  = DEF_CPU_START + DEF_SETUP_CLKS - 1;
    localparam int CPU_S0    = DEF_CPU_START + DEF_SETUP_CLKS;
    localparam int CPU_S1    = CPU_S0 + DEF_STROBE_CLKS - 1;
    localparam int MAX_LAT   = CYC + DEF_PI_START + DEF_SETUP_CLKS + DEF_STROBE_CLKS;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bus_slot_sequencer_if bus();

    bus_slot_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_time = 0;
    int ack_seen = 0;
    bit ack_now = 1'b0;

    // Reference state: what the slot rules say about the cycle in progress.
    int m_cnt = 0;
    bit m_active = 1'b0;
    bit m_rw = 1'b0;
    bit m_served = 1'b0;
    bit m_cpu_rw = 1'b0;
    bit m_stall = 1'b0;

    typedef struct {
        string       name;
        bit          req;
        bit          pi_rw;
        bit          cpu_rw;
        logic [15:0] phi2;
        logic [15:0] owner;
        logic [15:0] cpu_rd;
        logic [15:0] cpu_wr;
        logic [15:0] pi_rd;
        logic [15:0] pi_wr;
        logic [15:0] ack;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, cyc_time);
        end
    endtask

    task automatic check_le(input string name, input int act, input int limit);
        checks++;
        if (act > limit) begin
            errors++;
            $display("FAIL %s: got %0d expected at most %0d (t=%0d)", name, act, limit, cyc_time);
        end
    endtask

    function automatic logic [6:0] pack_out();
        return {bus.phi2, bus.bus_owner, bus.cpu_read_strobe, bus.cpu_write_strobe,
                bus.pi_read_strobe, bus.pi_write_strobe, bus.pi_ack};
    endfunction

    function automatic logic [6:0] model_out();
        bit phi2, owner, crd, cwr, prd, pwr, ack, in_cpu, in_pi;
        in_cpu = (m_cnt >= CPU_S0) && (m_cnt <= CPU_S1) && !m_stall;
        in_pi  = (m_cnt >= PI_S0) && (m_cnt <= PI_S1) && m_active;
        phi2   = (m_cnt >= DEF_CPU_START) && !m_stall;
        owner  = m_active && (m_cnt >= DEF_PI_START) && (m_cnt <= PI_HOLD);
        crd    = in_cpu && m_cpu_rw;
        cwr    = in_cpu && !m_cpu_rw;
        prd    = in_pi && m_rw;
        pwr    = in_pi && !m_rw;
        ack    = m_active && (m_cnt == PI_HOLD);
        return {phi2, owner, crd, cwr, prd, pwr, ack};
    endfunction

    task automatic model_advance(input bit rst, input bit req, input bit rw,
                                 input bit cpu_rw, input bit stall);
        int c_old;
        int c_new;
        if (rst) begin
            m_cnt = 0; m_active = 0; m_rw = 0; m_served = 0; m_cpu_rw = 0; m_stall = 0;
        end else begin
            c_old = m_cnt;
            c_new = (m_cnt + 1) % CYC;
            if (c_old == PI_SAMPLE) begin
                m_active = req && !m_served;
                m_rw     = rw;
            end
            if (c_old == CPU_SAMP) m_cpu_rw = cpu_rw;
            if (c_old == CYC - 1) m_stall = stall;
            if (m_active && c_new == PI_HOLD) m_served = 1'b1;
            else if (!req) m_served = 1'b0;
            m_cnt = c_new;
        end
    endtask

    task automatic step();
        logic s_rst, s_req, s_rw, s_cpu, s_stall;
        s_rst = reset; s_req = bus.pi_req; s_rw = bus.pi_rw_b; s_cpu = bus.cpu_rw_b;
        s_stall = 1'b0;
`ifdef BUS_SLOT_CPU_STALL_EN
        s_stall = bus.cpu_stall;
`endif
        @(posedge clk);
        model_advance(s_rst, s_req, s_rw, s_cpu, s_stall);
        #1;
        cyc_time++;
        ack_now = bus.pi_ack;
        if (ack_now) ack_seen++;
        check($sformatf("outputs cnt=%0d", m_cnt), {25'd0, pack_out()}, {25'd0, model_out()});
    endtask

    task automatic goto_count(input int k);
        int n;
        n = 0;
        while (m_cnt != k && n < 2 * CYC) begin
            step();
            n++;
        end
    endtask

    task automatic wait_ack(output int elapsed);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ack_now && n < 64);
        elapsed = n;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int a0;
        int idle;
        int raise_t;
        int phi_hi;
        int cstb;
        int acks;

        bus.pi_req = 1'b0;
        bus.pi_rw_b = 1'b0;
        bus.cpu_rw_b = 1'b1;
`ifdef BUS_SLOT_CPU_STALL_EN
        bus.cpu_stall = 1'b0;
`endif

        vecs[0] = '{"idle_cpu_read", 1'b0, 1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h1E00, 16'h0000,
                    16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{"pi_write_cpu_read", 1'b1, 1'b0, 1'b1, 16'hFF00, 16'h007E, 16'h1E00, 16'h0000,
                    16'h0000, 16'h003C, 16'h0040};
        vecs[2] = '{"pi_read_cpu_write", 1'b1, 1'b1, 1'b0, 16'hFF00, 16'h007E, 16'h0000, 16'h1E00,
                    16'h003C, 16'h0000, 16'h0040};
        vecs[3] = '{"idle_cpu_write", 1'b0, 1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h0000, 16'h1E00,
                    16'h0000, 16'h0000, 16'h0000};

        // Reset state
        repeat (3) step();
        check("reset_state", {25'd0, pack_out()}, 32'd0);
        reset = 1'b0;

        // Vector table: one full CPU cycle per row
        for (int r = 0; r < 4; r++) begin
            bus.pi_req = 1'b0;
            goto_count(CYC - 1);
            step();
            bus.pi_req   = vecs[r].req;
            bus.pi_rw_b  = vecs[r].pi_rw;
            bus.cpu_rw_b = vecs[r].cpu_rw;
            for (int k = 1; k <= CYC; k++) begin
                int c;
                step();
                c = k % CYC;
                check($sformatf("%s cnt=%0d", vecs[r].name, c), {25'd0, pack_out()},
                      {25'd0, vecs[r].phi2[c], vecs[r].owner[c], vecs[r].cpu_rd[c],
                       vecs[r].cpu_wr[c], vecs[r].pi_rd[c], vecs[r].pi_wr[c], vecs[r].ack[c]});
            end
        end

        // Request held for three cycles gives a single ack
        bus.pi_req = 1'b0;
        goto_count(CYC - 1);
        step();
        a0 = ack_seen;
        bus.pi_req = 1'b1;
        bus.pi_rw_b = 1'b1;
        repeat (3 * CYC) step();
        check("held_req_single_ack", ack_seen - a0, 1);
        goto_count(CYC - 1);
        bus.pi_req = 1'b0;
        step();
        bus.pi_req = 1'b1;
        wait_ack(lat);
        check("rereq_latency", lat, PI_HOLD);
        bus.pi_req = 1'b0;

        // Request raised after the sample point waits a full cycle
        goto_count(3);
        bus.pi_req = 1'b1;
        bus.pi_rw_b = 1'b0;
        wait_ack(lat);
        check("late_req_latency", lat, CYC + PI_HOLD - 3);
        bus.pi_req = 1'b0;

        // Reset in the middle of an active Pi write
        goto_count(CYC - 1);
        step();
        bus.pi_req = 1'b1;
        bus.pi_rw_b = 1'b0;
        repeat (3) step();
        check("midslot_write_strobe", bus.pi_write_strobe, 1'b1);
        a0 = ack_seen;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {25'd0, pack_out()}, 32'd0);
        repeat (3) step();
        reset = 1'b0;
        wait_ack(lat);
        check("reserve_after_reset", lat, PI_HOLD);
        check("reset_ack_count", ack_seen - a0, 1);
        bus.pi_req = 1'b0;

`ifdef BUS_SLOT_CPU_STALL_EN
        // Stalled CPU cycle with a Pi read in the same cycle
        goto_count(CYC - 1);
        bus.cpu_stall = 1'b1;
        bus.pi_req = 1'b1;
        bus.pi_rw_b = 1'b1;
        step();
        bus.cpu_stall = 1'b0;
        phi_hi = 0; cstb = 0; acks = 0;
        for (int k = 1; k <= CYC; k++) begin
            step();
            if (bus.phi2) phi_hi++;
            if (bus.cpu_read_strobe || bus.cpu_write_strobe) cstb++;
            if (ack_now) begin
                acks++;
                check("stall_ack_count_pos", m_cnt, PI_HOLD);
                bus.pi_req = 1'b0;
            end
        end
        check("stall_phi2_clocks", phi_hi, 0);
        check("stall_cpu_strobes", cstb, 0);
        check("stall_pi_acks", acks, 1);
        phi_hi = 0;
        for (int k = 1; k <= CYC; k++) begin
            step();
            if (bus.phi2) phi_hi++;
        end
        check("post_stall_phi2_clocks", phi_hi, CYC - DEF_CPU_START);
`endif

        // Randomized requester following the 4-phase protocol
        bus.pi_req = 1'b0;
        idle = 2;
        raise_t = cyc_time;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (bus.pi_req && ack_now) begin
                check_le("rand_latency", cyc_time - raise_t, MAX_LAT);
                bus.pi_req = 1'b0;
                idle = $urandom_range(1, 25);
            end else if (!bus.pi_req) begin
                if (idle > 0) begin
                    idle--;
                end else begin
                    bus.pi_req = 1'b1;
                    bus.pi_rw_b = 1'($urandom_range(0, 1));
                    raise_t = cyc_time;
                end
            end else if (cyc_time - raise_t > 64) begin
                check_le("rand_latency", cyc_time - raise_t, MAX_LAT);
                bus.pi_req = 1'b0;
                idle = 2;
            end
            bus.cpu_rw_b = 1'($urandom_range(0, 1));
`ifdef BUS_SLOT_CPU_STALL_EN
            bus.cpu_stall = ($urandom_range(0, 7) == 0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
